// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI write slave: burst type encoding, write
// response codes and the slave FSM state type.
// ----------------------------------------------------------------------------
package axi_pkg;

    // Burst type as carried on awburst.
    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    // Write response codes carried on bresp.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Slave FSM: accept address, take data beats, hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/axi_wr_slave_if.sv
// ----------------------------------------------------------------------------
// axi_wr_slave_if
// AXI write channels (AW, W, B) between a master and the write slave.
//   AW : awvalid/awready, awid, awlen, awsize, awaddr, awburst
//   W  : wvalid/wready, wid, wdata, wstrb, wlast
//   B  : bvalid/bready, bid, bresp
// Modports: master drives AW/W and bready; slave drives the readies and B.
// ----------------------------------------------------------------------------
interface axi_wr_slave_if;

    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [31:0] awaddr;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    modport slave (
        input  awvalid, awid, awlen, awsize, awaddr, awburst,
        input  wvalid, wid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bid, bresp
    );

    modport master (
        output awvalid, awid, awlen, awsize, awaddr, awburst,
        output wvalid, wid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bid, bresp
    );

endinterface

// File: rtl/axi_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_addr_gen
// Combinational next-beat byte address for an AXI burst.
//   addr      in  32  current beat byte address
//   size      in   3  log2(bytes per beat)
//   len       in   4  beats minus one
//   burst     in      FIXED / INCR / WRAP (RSVD steps like INCR)
//   next_addr out 32  byte address of the following beat
// ----------------------------------------------------------------------------
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  burst_t      burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] span;
    logic [31:0] lower;
    logic [31:0] sum;

    always_comb begin
        step  = 32'd1 << size;
        // Legal wrap lengths make span a power of two, so masking aligns down.
        span  = ({28'd0, len} + 32'd1) << size;
        lower = addr & ~(span - 32'd1);
        sum   = addr + step;

        case (burst)
            FIXED:   next_addr = addr;
            // Offset-based compare avoids overflow of lower+span at the top of memory.
            WRAP:    next_addr = ((sum - lower) >= span) ? lower : sum;
            default: next_addr = sum;
        endcase
    end

endmodule

// File: rtl/axi_wr_slave.sv
// ----------------------------------------------------------------------------
// axi_wr_slave
// AXI write slave that forwards each accepted data beat straight to a simple
// word-addressed memory port in the same cycle.
//   clk        in        sole clock, rising edge
//   rstn       in        asynchronous active-low reset
//   axi        slave     AW / W / B channels (axi_wr_slave_if)
//   mem_we     out   1   memory write strobe
//   mem_addr   out  30   word index (beat byte address >> 2)
//   mem_wdata  out  32   write data
//   mem_wstrb  out   4   byte-lane enables
// Parameter MEM_BYTES: memory size in bytes.
// Build option AXI_WR_ERR_CHECK_EN: when defined, illegal bursts, out-of-range
// beats and wid/wlast mismatches produce SLVERR; when undefined the response is
// always OKAY and illegal settings are folded onto legal ones.
// ----------------------------------------------------------------------------
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    axi_wr_slave_if.slave axi,
    output logic          mem_we,
    output logic [29:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state;
    state_t      state_nxt;
    logic        alive;

    logic [3:0]  id_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt_q;
    logic [2:0]  size_q;
    burst_t      burst_q;
    logic [31:0] addr_q;
    logic [31:0] addr_nxt;
    logic        bad_q;     // header was illegal: drop every beat
    logic        err_q;     // any error seen so far in this burst

    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        last_beat;

    logic [2:0]  size_in;
    burst_t      burst_in;
    logic        hdr_err;
    logic        beat_ok;
    logic        beat_err;
    logic [31:0] mem_byte;

    assign aw_hs     = axi.awvalid && axi.awready;
    assign w_hs      = axi.wvalid && axi.wready;
    assign b_hs      = axi.bvalid && axi.bready;
    // Only the beat counter ends a burst; wlast is at most checked.
    assign last_beat = (cnt_q == len_q);

`ifdef AXI_WR_ERR_CHECK_EN
    always_comb begin
        size_in  = axi.awsize;
        burst_in = burst_t'(axi.awburst);
        hdr_err  = (axi.awburst == RSVD) || (axi.awsize > 3'd2) ||
                   ((axi.awburst == WRAP) &&
                    !(axi.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
        mem_byte = addr_q;
        beat_ok  = !bad_q && (addr_q < MEM_LIMIT);
        // Protocol mismatches flag the response but the beat is still written.
        beat_err = !beat_ok || (axi.wid != id_q) || (axi.wlast != last_beat);
    end

    logic unused_bits;
    assign unused_bits = ^mem_byte[1:0];
`else
    always_comb begin
        size_in  = (axi.awsize > 3'd2) ? 3'd2 : axi.awsize;
        burst_in = (axi.awburst == RSVD) ? INCR : burst_t'(axi.awburst);
        hdr_err  = 1'b0;
        mem_byte = addr_q % MEM_LIMIT;
        beat_ok  = 1'b1;
        beat_err = 1'b0;
    end

    logic unused_inputs;
    assign unused_inputs = ^{axi.wid, axi.wlast, mem_byte[1:0], bad_q};
`endif

    axi_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    // ---------------------------------------------------------------- FSM --
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of all other flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state is IDLE during reset, yet awready must stay low until the
    // first edge after release; this flag provides that one-edge delay.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi.awready = (state == IDLE) && alive;
        axi.wready  = (state == DATA);
        axi.bvalid  = (state == RESP);
        axi.bid     = (state == RESP) ? id_q : 4'd0;
        axi.bresp   = ((state == RESP) && err_q) ? SLVERR : OKAY;
    end

    // ---------------------------------------------------- burst context --
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= FIXED;
            addr_q  <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= axi.awid;
            len_q   <= axi.awlen;
            cnt_q   <= '0;
            size_q  <= size_in;
            burst_q <= burst_in;
            addr_q  <= axi.awaddr;
            bad_q   <= hdr_err;
            err_q   <= hdr_err;
        end else if (w_hs) begin
            addr_q  <= addr_nxt;
            cnt_q   <= cnt_q + 4'd1;
            err_q   <= err_q | beat_err;
        end
    end

    // ------------------------------------------------------- memory port --
    // Zero-latency pass-through; the data outputs are zeroed whenever no
    // write is issued so the port is quiet in reset and between beats.
    always_comb begin
        mem_we    = w_hs && beat_ok;
        mem_addr  = mem_we ? mem_byte[31:2] : 30'd0;
        mem_wdata = mem_we ? axi.wdata : 32'd0;
        mem_wstrb = mem_we ? axi.wstrb : 4'd0;
    end

endmodule

// File: tb/tb_axi_wr_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_wr_slave
// Self-checking bench for axi_wr_slave. The driver knows, from the burst rules,
// what every output must be in every cycle and publishes that as e_*; a single
// negedge process compares all outputs against it. Directed bursts pin literal
// memory addresses and responses; randomized bursts follow.
// ----------------------------------------------------------------------------
module tb_axi_wr_slave;
    import axi_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    axi_wr_slave_if axi ();

    axi_wr_slave #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .axi       (axi),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    // Expected outputs for the current cycle.
    logic        e_awready, e_wready, e_bvalid, e_we;
    logic [3:0]  e_bid, e_wstrb;
    logic [1:0]  e_bresp;
    logic [29:0] e_maddr;
    logic [31:0] e_wdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [29:0] wr_log[$];
    logic [3:0]  b_last_id;
    logic [1:0]  b_last_resp;
    int          b_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        check("awready",   32'(axi.awready), 32'(e_awready));
        check("wready",    32'(axi.wready),  32'(e_wready));
        check("bvalid",    32'(axi.bvalid),  32'(e_bvalid));
        check("bid",       32'(axi.bid),     32'(e_bid));
        check("bresp",     32'(axi.bresp),   32'(e_bresp));
        check("mem_we",    32'(mem_we),      32'(e_we));
        check("mem_addr",  32'(mem_addr),    32'(e_maddr));
        check("mem_wdata", mem_wdata,        e_wdata);
        check("mem_wstrb", 32'(mem_wstrb),   32'(e_wstrb));
        if (mem_we) wr_log.push_back(mem_addr);
        if (axi.bvalid && axi.bready) begin
            b_last_id   = axi.bid;
            b_last_resp = axi.bresp;
            b_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic awr, input logic wr, input logic bv,
                           input logic [3:0] bid_v, input logic [1:0] br,
                           input logic we, input logic [29:0] ma,
                           input logic [31:0] wd, input logic [3:0] ws);
        e_awready = awr; e_wready = wr; e_bvalid = bv; e_bid = bid_v; e_bresp = br;
        e_we = we; e_maddr = ma; e_wdata = wd; e_wstrb = ws;
    endtask

    // Random values on every master signal; callers then pin what matters.
    task automatic noise_inputs();
        axi.awvalid = 1'($urandom);
        axi.awid    = 4'($urandom);
        axi.awlen   = 4'($urandom);
        axi.awsize  = 3'($urandom);
        axi.awaddr  = $urandom();
        axi.awburst = 2'($urandom);
        axi.wvalid  = 1'($urandom);
        axi.wid     = 4'($urandom);
        axi.wdata   = $urandom();
        axi.wstrb   = 4'($urandom);
        axi.wlast   = 1'($urandom);
        axi.bready  = 1'($urandom);
    endtask

    // Byte address of beat i, straight from the burst definitions.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] len,
                                               input logic [2:0] sz, input logic [1:0] bt,
                                               input int i);
        logic [31:0] bytes, wb, lower;
        bytes = 32'd1 << sz;
        case (bt)
            2'b00: return a;
            2'b10: begin
                wb    = bytes * (len + 32'd1);
                lower = a - (a % wb);
                return lower + ((a - lower + bytes * i) % wb);
            end
            default: return a + bytes * i;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            noise_inputs();
            axi.awvalid = 1'b0;
            set_exp(1, 0, 0, 0, OKAY, 0, 0, 0, 0);
            tick();
        end
    endtask

    // One complete burst from an IDLE slave. abort_after >= 0 pulses reset
    // just before that beat index and returns with the slave back in IDLE.
    task automatic do_burst(input logic [3:0] id, input logic [3:0] len, input logic [2:0] size,
                            input logic [31:0] addr, input logic [1:0] burst,
                            input int bdelay, input int inject, input int abort_after);
        logic [2:0]  es;
        logic [1:0]  eb;
        bit          hdr_bad, any_err, we;
        logic [31:0] ba;
        logic [29:0] ma;
        es = size;
        eb = burst;
`ifdef AXI_WR_ERR_CHECK_EN
        hdr_bad = (burst == 2'b11) || (size > 3'd2) ||
                  ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
`else
        hdr_bad = 1'b0;
        if (size > 3'd2) es = 3'd2;
        if (burst == 2'b11) eb = 2'b01;
`endif
        any_err = hdr_bad;

        noise_inputs();
        axi.awvalid = 1'b1;
        axi.awid    = id;
        axi.awlen   = len;
        axi.awsize  = size;
        axi.awaddr  = addr;
        axi.awburst = burst;
        set_exp(1, 0, 0, 0, OKAY, 0, 0, 0, 0);
        tick();

        for (int i = 0; i <= int'(len); i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < 20; g++) begin
                noise_inputs();
                axi.wvalid = 1'b0;
                set_exp(0, 1, 0, 0, OKAY, 0, 0, 0, 0);
                tick();
            end
            if (i == abort_after) begin
                noise_inputs();
                axi.wvalid = 1'b1;
                rstn = 1'b0;
                set_exp(0, 0, 0, 0, OKAY, 0, 0, 0, 0);
                tick();
                tick();
                rstn = 1'b1;
                tick();
                return;
            end
            noise_inputs();
            axi.wvalid = 1'b1;
            axi.wid    = (inject == 1 && i == 0) ? ~id : id;
            axi.wlast  = (inject == 3) ? 1'b0 : ((i == int'(len)) || (inject == 2 && i == 0));
            ba = model_addr(addr, len, es, eb, i);
`ifdef AXI_WR_ERR_CHECK_EN
            we = !hdr_bad && (ba < MEM_BYTES);
            ma = ba[31:2];
            any_err |= !we || (axi.wid != id) || (axi.wlast != (i == int'(len)));
`else
            we = 1'b1;
            ma = 30'((ba % MEM_BYTES) >> 2);
`endif
            set_exp(0, 1, 0, 0, OKAY, we, we ? ma : 30'd0,
                    we ? axi.wdata : 32'd0, we ? axi.wstrb : 4'd0);
            tick();
        end

        for (int d = 0; d <= bdelay; d++) begin
            noise_inputs();
            axi.bready = (d == bdelay);
            set_exp(0, 0, 1, id, any_err ? SLVERR : OKAY, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic log_check(input string name, input int n,
                             input int a0, input int a1, input int a2, input int a3);
        int ex[4];
        ex = '{a0, a1, a2, a3};
        check({name, "_count"}, 32'(wr_log.size()), 32'(n));
        for (int k = 0; k < n; k++)
            check(name, (k < wr_log.size()) ? 32'(wr_log[k]) : 32'hDEAD_BEEF, 32'(ex[k]));
    endtask

    initial begin
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          b_before;

        rstn = 1'b0;
        noise_inputs();
        set_exp(0, 0, 0, 0, OKAY, 0, 0, 0, 0);
        repeat (3) tick();
        rstn = 1'b1;               // awready stays low until the next edge
        tick();
        idle(2);

        // INCR, 4 words from 0x10.
        wr_log.delete();
        do_burst(4'h5, 4'd3, 3'd2, 32'h10, 2'b01, 1, 0, -1);
        log_check("incr_addr", 4, 4, 5, 6, 7);
        check("incr_bid", 32'(b_last_id), 32'h5);
        check("incr_bresp", 32'(b_last_resp), 32'h0);

        // WRAP, 16-byte window: 0x38, 0x3C, 0x30, 0x34.
        wr_log.delete();
        do_burst(4'h9, 4'd3, 3'd2, 32'h38, 2'b10, 0, 0, -1);
        log_check("wrap_addr", 4, 14, 15, 12, 13);
        check("wrap_bresp", 32'(b_last_resp), 32'h0);

        // FIXED, 3 beats, response held 5 cycles before bready.
        wr_log.delete();
        do_burst(4'h2, 4'd2, 3'd2, 32'h20, 2'b00, 5, 0, -1);
        log_check("fixed_addr", 3, 8, 8, 8, 0);

        // Burst that crosses the end of memory.
        wr_log.delete();
        do_burst(4'h7, 4'd1, 3'd2, 32'h3FC, 2'b01, 0, 0, -1);
`ifdef AXI_WR_ERR_CHECK_EN
        log_check("edge_addr", 1, 255, 0, 0, 0);
        check("edge_bresp", 32'(b_last_resp), 32'h2);
`else
        log_check("edge_addr", 2, 255, 0, 0, 0);
        check("edge_bresp", 32'(b_last_resp), 32'h0);
`endif

        // Single beat with bready already high: AW n, W n+1, bvalid n+2.
        wr_log.delete();
        do_burst(4'hA, 4'd0, 3'd2, 32'h100, 2'b01, 0, 0, -1);
        log_check("single_addr", 1, 64, 0, 0, 0);
        check("single_bid", 32'(b_last_id), 32'hA);

        // Reset after beat 2 of 4: no more writes, no response.
        wr_log.delete();
        b_before = b_count;
        do_burst(4'h4, 4'd3, 3'd2, 32'h40, 2'b01, 0, 0, 2);
        log_check("abort_addr", 2, 16, 17, 0, 0);
        check("abort_no_b", 32'(b_count), 32'(b_before));
        wr_log.delete();
        do_burst(4'h3, 4'd0, 3'd2, 32'h80, 2'b01, 0, 0, -1);
        log_check("after_abort_addr", 1, 32, 0, 0, 0);
        check("after_abort_bid", 32'(b_last_id), 32'h3);

        for (int n = 0; n < 60; n++) begin
            len   = 4'($urandom);
            burst = 2'($urandom);
`ifdef AXI_WR_ERR_CHECK_EN
            size = ($urandom_range(7) == 0) ? 3'($urandom) : 3'($urandom_range(2));
            addr = $urandom_range(MEM_BYTES + 63);
            if (burst == 2'b10 && $urandom_range(3) != 0) len = 4'((2 << $urandom_range(3)) - 1);
`else
            size = 3'($urandom);
            addr = $urandom();
            if (burst == 2'b10) len = 4'((2 << $urandom_range(3)) - 1);
`endif
            if (burst == 2'b10) addr = addr & ~32'h3;
            do_burst(4'($urandom), len, size, addr, burst, $urandom_range(3),
                     ($urandom_range(1) == 1) ? 0 : $urandom_range(1, 3), -1);
            idle($urandom_range(2));
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 MEM_BYTES  default 1024  memory size in bytes; any byte address >= MEM_BYTES is out of range.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 awvalid/awready  in/out  1/1  write-address handshake.
REQ-005 awid  in  4  transaction ID.
REQ-006 awlen  in  4  beats minus one (1..16 beats).
REQ-007 awsize  in  3  bytes per beat = 2^awsize.
REQ-008 awaddr  in  32  start byte address.
REQ-009 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 wvalid/wready  in/out  1/1  write-data handshake.
REQ-011 wid  in  4  data ID.
REQ-012 wdata/wstrb  in  32/4  beat data and byte-lane enables.
REQ-013 wlast  in  1  master's last-beat marker.
REQ-014 bvalid/bready  out/in  1/1  write-response handshake.
REQ-015 bid/bresp  out  4/2  response ID and status (00 OKAY, 10 SLVERR).
REQ-016 mem_we  out  1  memory write strobe.
REQ-017 mem_addr  out  30  word index = beat byte address[31:2].
REQ-018 mem_wdata/mem_wstrb  out  32/4  data and lane enables to memory.

Function
REQ-019 FSM IDLE/DATA/RESP: awready=1 only in IDLE; on the AW handshake latch awid/awlen/awsize/awaddr/awburst and move to DATA next cycle.
REQ-020 wready=1 only in DATA; on each W handshake, in the same cycle, mem_we=1, mem_addr=current beat address[31:2], mem_wdata=wdata, mem_wstrb=wstrb (zero latency); otherwise mem_we=0.
REQ-021 Beat address: FIXED holds awaddr; INCR adds 2^awsize; WRAP adds 2^awsize and wraps to the lower boundary (awaddr aligned down to 2^awsize*(awlen+1)) on reaching the upper boundary.
REQ-022 Burst termination by beat counter only: the handshake of beat awlen+1 moves to RESP; wlast never terminates a burst.
REQ-023 RESP: bvalid=1, bid=latched awid, bresp held stable until bready; the B handshake returns to IDLE and awready rises the following cycle.
REQ-024 awvalid outside IDLE and wvalid outside DATA are ignored, with no state change.
REQ-025 bready already high when bvalid rises: handshake completes in that cycle, bvalid is a one-cycle pulse.
REQ-026 Minimum single-beat turnaround: AW handshake at cycle n, W handshake at n+1, bvalid at n+2.

Reset
REQ-027 While rstn=0: state IDLE; awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata and mem_wstrb all 0; awready rises at the first clk edge after rstn deasserts.
REQ-028 Reset mid-burst abandons the burst: no further memory writes and no B response is issued.

Configuration
REQ-029 AXI_WR_ERR_CHECK_EN defined: SLVERR for awburst=11, awsize>2, WRAP with awlen not 1/3/7/15, or any out-of-range beat, with mem_we suppressed for those beats (whole burst for burst/size/len errors); SLVERR for wid!=awid or wlast mismatch (early or missing), with beats still written.
REQ-030 AXI_WR_ERR_CHECK_EN undefined: bresp always OKAY; awburst=11 treated as INCR; addresses taken modulo MEM_BYTES; awsize>2 treated as 2.

Structure
REQ-031 Shared package axi_pkg holds the burst encoding typedef (FIXED/INCR/WRAP), response constants OKAY/SLVERR and the FSM state typedef.
REQ-032 One sub-module, axi_addr_gen, holds the combinational next-beat address calculation (addr, size, len, burst in; next addr out).

Verification
REQ-033 INCR awaddr=0x10, awlen=3, awsize=2, 4 beats -> mem_addr 4,5,6,7; bresp=00; bid=awid.
REQ-034 WRAP awaddr=0x38, awlen=3, awsize=2 -> byte addresses 0x38,0x3C,0x30,0x34; bresp=00.
REQ-035 FIXED awaddr=0x20, awlen=2 -> mem_addr 8 three times; bready held low 5 cycles -> bvalid and bresp stable throughout.
REQ-036 (ERR_CHECK_EN) awaddr=0x3FC, awlen=1, INCR, MEM_BYTES=1024 -> first beat written, second mem_we=0, bresp=10.
REQ-037 rstn pulsed low after beat 2 of a 4-beat burst -> all outputs 0 immediately; no bvalid; next AW accepted normally.
